// File: rtl/lzc_pattern_gen.sv
// Builds a WIDTH-bit vector with a requested number of leading zeros, a 1 after them and filler below.
// Optional macro LZC_GEN_RANDFILL_EN: filler comes from a 32-bit Galois LFSR instead of zeros.
module lzc_pattern_gen #(
    parameter int          WIDTH = 64,
    parameter int          CW    = $clog2(WIDTH) + 1,
    parameter logic [31:0] SEED  = 32'hACE1_5EED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CW-1:0]    Z_req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] A,
    output logic [CW-2:0]    Z,
    output logic             n_V,
    output logic             sat
);

    localparam logic [CW-1:0] WIDTH_C   = CW'(WIDTH);
    localparam logic [31:0]   LFSR_MASK = 32'h8020_0003;
    localparam logic [31:0]   SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;

    logic             r_s1_valid;
    logic [CW-1:0]    r_s1_cnt;
    logic             r_s1_sat;
    logic [31:0]      w_s1_fill;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_a;
    logic [CW-2:0]    r_z;
    logic             r_nv;
    logic             r_sat;

    logic             w_s2_load;
    logic             w_accept;
    logic [WIDTH-1:0] w_fill_rep;
    logic [WIDTH-1:0] w_one;
    logic [WIDTH-1:0] w_a;

    // Stage 1 moves whenever stage 2 can take its contents, so in_ready only
    // drops when both stages hold data and the output is stalled.
    assign w_s2_load = ~r_out_valid | out_ready;
    assign in_ready  = ~r_s1_valid | w_s2_load;
    assign w_accept  = in_valid & in_ready;

`ifdef LZC_GEN_RANDFILL_EN
    logic [31:0] r_lfsr;
    logic [31:0] r_s1_fill;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr    <= SEED_EFF;
            r_s1_fill <= '0;
        end else if (w_accept) begin
            r_s1_fill <= r_lfsr;
            r_lfsr    <= r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_MASK) : (r_lfsr >> 1);
        end
    end

    assign w_s1_fill = r_s1_fill;
`else
    // Filler is constant zero; SEED only matters in the random-fill build.
    assign w_s1_fill = SEED_EFF & 32'h0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_cnt   <= '0;
            r_s1_sat   <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_cnt   <= (Z_req > WIDTH_C) ? WIDTH_C : Z_req;
            r_s1_sat   <= (Z_req > WIDTH_C);
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_fill
        assign w_fill_rep[g] = w_s1_fill[g % 32];
    end

    // Shifting the MSB right by cnt lands the leading 1; cnt == WIDTH shifts it out.
    assign w_one = {1'b1, {(WIDTH-1){1'b0}}} >> r_s1_cnt;
    assign w_a   = (r_s1_cnt == WIDTH_C) ? '0
                 : (w_one | (w_fill_rep & (w_one - WIDTH'(1))));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_z         <= '0;
            r_nv        <= 1'b0;
            r_sat       <= 1'b0;
        end else if (w_s2_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_a   <= w_a;
                r_z   <= r_s1_cnt[CW-2:0];
                r_nv  <= (r_s1_cnt == WIDTH_C);
                r_sat <= r_s1_sat;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign A         = r_a;
    assign Z         = r_z;
    assign n_V       = r_nv;
    assign sat       = r_sat;

endmodule

// File: tb/tb_lzc_pattern_gen.sv
// Self-checking bench for lzc_pattern_gen: randomized requests against a queue-based reference model.
// Works in both builds; the model follows LZC_GEN_RANDFILL_EN the same way the design does.
module tb_lzc_pattern_gen;

    localparam int          WIDTH = 64;
    localparam int          CW    = $clog2(WIDTH) + 1;
    localparam logic [31:0] SEED  = 32'hACE1_5EED;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [CW-1:0]    Z_req;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] A;
    logic [CW-2:0]    Z;
    logic             n_V;
    logic             sat;

    lzc_pattern_gen #(.WIDTH(WIDTH), .CW(CW), .SEED(SEED)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .Z_req(Z_req),
        .out_valid(out_valid), .out_ready(out_ready),
        .A(A), .Z(Z), .n_V(n_V), .sat(sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [CW-2:0]    z;
        logic             nv;
        logic             sat;
    } res_t;

    res_t        exp_q[$];
    int          cnt_q[$];
    logic [31:0] m_lfsr;
    int          n_tests = 0;
    int          n_fail  = 0;

    // Values sampled by cycle() just before the rising edge.
    res_t obs;
    logic acc, cons, ov;

    // Expected vector: zeros above the leading one, filler (fill word repeated every 32 bits) below.
    function automatic res_t model(input int zreq, input logic [31:0] fill);
        res_t r;
        int   c;
        c = (zreq > WIDTH) ? WIDTH : zreq;
        r.a = '0;
        for (int i = 0; i < WIDTH; i++) begin
            int k;
            k = WIDTH - 1 - i;
            if (k < c)       r.a[i] = 1'b0;
            else if (k == c) r.a[i] = 1'b1;
            else             r.a[i] = fill[i % 32];
        end
        r.z   = c[CW-2:0];
        r.nv  = (c == WIDTH);
        r.sat = (zreq > WIDTH);
        return r;
    endfunction

    function automatic int clz(input logic [WIDTH-1:0] a);
        for (int i = WIDTH - 1; i >= 0; i--)
            if (a[i]) return WIDTH - 1 - i;
        return WIDTH;
    endfunction

    task automatic model_accept(input int zreq);
        logic [31:0] fill;
        logic        fb;
        fill = 32'h0;
`ifdef LZC_GEN_RANDFILL_EN
        fill = m_lfsr;
`endif
        exp_q.push_back(model(zreq, fill));
        cnt_q.push_back((zreq > WIDTH) ? WIDTH : zreq);
        // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
        fb     = m_lfsr[0];
        m_lfsr = {1'b0, m_lfsr[31:1]};
        if (fb) m_lfsr = m_lfsr ^ 32'h8020_0003;
    endtask

    task automatic model_reset();
        exp_q.delete();
        cnt_q.delete();
        m_lfsr = (SEED == 32'h0) ? 32'h1 : SEED;
    endtask

    // One clock: drive at the falling edge, sample 1 ns later, then advance to the next falling edge.
    task automatic cycle(input logic iv, input int zr, input logic ordy);
        in_valid  = iv;
        Z_req     = CW'(zr);
        out_ready = ordy;
        #1;
        acc  = in_valid & in_ready;
        cons = out_valid & out_ready;
        ov   = out_valid;
        obs  = {A, Z, n_V, sat};
        if (acc) model_accept(zr);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        Z_req = '0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({out_valid, A, Z, n_V, sat} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ov=%b A=%h Z=%0d nV=%b sat=%b, want all zero",
                     out_valid, A, Z, n_V, sat);
        end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_corners();
        int reqs[4] = '{0, 63, 64, 100};
        foreach (reqs[i]) begin
            int   k;
            res_t e;
            int   c;
            acc = 1'b0;
            k = 0;
            while (!acc && k < 10) begin
                cycle(1'b1, reqs[i], 1'b1);
                k++;
            end
            cons = 1'b0;
            k = 0;
            while (!cons && k < 10) begin
                cycle(1'b0, 0, 1'b1);
                k++;
            end
            n_tests++;
            if (!cons || exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL corner_timeout: req=%0d accepted=%b consumed=%b", reqs[i], acc, cons);
                model_reset();
            end else begin
                e = exp_q.pop_front();
                c = cnt_q.pop_front();
                if (obs !== e || clz(obs.a) != c) begin
                    n_fail++;
                    $display("FAIL corner_req%0d: got A=%h Z=%0d nV=%b sat=%b, want A=%h Z=%0d nV=%b sat=%b",
                             reqs[i], obs.a, obs.z, obs.nv, obs.sat, e.a, e.z, e.nv, e.sat);
                end
            end
        end
    endtask

    task automatic test_throughput();
        int sent = 0, got = 0, first_valid = -1, last_valid = -1, n_valid = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            cycle(sent < 65, sent, 1'b1);
            if (acc) sent++;
            if (ov) begin
                if (first_valid < 0) first_valid = cyc;
                last_valid = cyc;
                n_valid++;
            end
            if (cons) begin
                res_t e;
                int   c;
                got++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL thru_extra: unexpected output A=%h", obs.a);
                end else begin
                    e = exp_q.pop_front();
                    c = cnt_q.pop_front();
                    if (obs !== e || {obs.nv, obs.z} != CW'(c)) begin
                        n_fail++;
                        $display("FAIL thru_order: got A=%h Z=%0d nV=%b, want A=%h Z=%0d nV=%b",
                                 obs.a, obs.z, obs.nv, e.a, e.z, e.nv);
                    end
                end
            end
        end
        n_tests++;
        if (first_valid != 2) begin
            n_fail++;
            $display("FAIL thru_latency: first out_valid cycle %0d want 2", first_valid);
        end
        n_tests++;
        if (n_valid != 65 || last_valid - first_valid != 64 || got != 65) begin
            n_fail++;
            $display("FAIL thru_bubbles: valid cycles %0d span %0d results %0d, want 65/64/65",
                     n_valid, last_valid - first_valid, got);
        end
    endtask

    task automatic test_backpressure();
        int   accepts = 0, n_new = 0, got = 0;
        res_t held;
        for (int cyc = 0; cyc < 5; cyc++) begin
            cycle(1'b1, int'($urandom_range(0, 127)), 1'b0);
            if (acc) accepts++;
            if (cyc == 2) held = obs;
            if (cyc > 2) begin
                n_tests++;
                if (obs !== held || ov !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_stable: cycle %0d got A=%h ov=%b, want A=%h ov=1", cyc, obs.a, ov, held.a);
                end
            end
        end
        n_tests++;
        if (accepts != 2 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_accepts: got %0d accepts in_ready=%b, want 2 accepts in_ready=0", accepts, in_ready);
        end
        for (int cyc = 0; cyc < 20; cyc++) begin
            cycle(n_new < 4, int'($urandom_range(0, 127)), 1'b1);
            if (acc) n_new++;
            if (cons) begin
                res_t e;
                got++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_extra: unexpected output A=%h", obs.a);
                end else begin
                    e = exp_q.pop_front();
                    void'(cnt_q.pop_front());
                    if (obs !== e) begin
                        n_fail++;
                        $display("FAIL bp_order: got A=%h Z=%0d sat=%b, want A=%h Z=%0d sat=%b",
                                 obs.a, obs.z, obs.sat, e.a, e.z, e.sat);
                    end
                end
            end
        end
        n_tests++;
        if (got != 6 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_count: got %0d results, %0d left, want 6 and 0", got, exp_q.size());
        end
    endtask

    task automatic test_random();
        logic prev_stall = 1'b0;
        res_t prev_obs   = '0;
        for (int cyc = 0; cyc < 430; cyc++) begin
            logic iv, ordy;
            int   zr;
            iv   = (cyc < 400) && ($urandom_range(0, 9) < 7);
            ordy = (cyc >= 400) || ($urandom_range(0, 9) < 6);
            zr   = ($urandom_range(0, 9) < 3) ? int'($urandom_range(60, 68)) : int'($urandom_range(0, 127));
            cycle(iv, zr, ordy);
            if (prev_stall) begin
                n_tests++;
                if (obs !== prev_obs || ov !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rand_hold: cycle %0d got A=%h ov=%b, want A=%h ov=1", cyc, obs.a, ov, prev_obs.a);
                end
            end
            prev_stall = ov & ~ordy;
            prev_obs   = obs;
            if (cons) begin
                res_t e;
                int   c;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra: unexpected output A=%h", obs.a);
                end else begin
                    e = exp_q.pop_front();
                    c = cnt_q.pop_front();
                    if (obs !== e || clz(obs.a) != c || {obs.nv, obs.z} != CW'(c)) begin
                        n_fail++;
                        $display("FAIL rand_out: cnt=%0d got A=%h Z=%0d nV=%b sat=%b, want A=%h Z=%0d nV=%b sat=%b",
                                 c, obs.a, obs.z, obs.nv, obs.sat, e.a, e.z, e.nv, e.sat);
                    end
                end
            end
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_drain: %0d results never emerged, want 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        int sent = 0, got = 0;
        cycle(1'b1, 5, 1'b0);
        cycle(1'b1, 17, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || A !== '0) begin
            n_fail++;
            $display("FAIL midreset_async: got ov=%b A=%h, want ov=0 A=0", out_valid, A);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int cyc = 0; cyc < 10; cyc++) begin
            cycle(sent < 2, (sent == 0) ? 8 : 20, 1'b1);
            if (acc) sent++;
            if (cons) begin
                res_t e;
                got++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL midreset_extra: unexpected output A=%h", obs.a);
                end else begin
                    e = exp_q.pop_front();
                    void'(cnt_q.pop_front());
                    if (obs !== e) begin
                        n_fail++;
                        $display("FAIL midreset_out%0d: got A=%h Z=%0d, want A=%h Z=%0d",
                                 got, obs.a, obs.z, e.a, e.z);
                    end
                end
            end
        end
        n_tests++;
        if (got != 2) begin
            n_fail++;
            $display("FAIL midreset_count: got %0d results want 2", got);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        Z_req = '0;
        m_lfsr = SEED;
        test_reset();
        test_corners();
        test_throughput();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
